// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its consumer.
package inst_fetch_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned ADDR_W = 32;

   // Word driven on inst whenever no real instruction is held.
   localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

   // Fetch FSM state encoding.
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_ERR   = 2'd3
   } fetch_state_e;

   // Force a byte address onto a word boundary.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      word_align = {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake, supports stall, redirect and a sticky fetch timeout fault.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT,
   parameter int unsigned       TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   output logic [ADDR_W-1:0] pc_out,
   output logic              fetch_err
);

   localparam int unsigned TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

   fetch_state_e      state_q,      state_d;
   logic [ADDR_W-1:0] pc_q,         pc_d;
   logic              imem_req_q,   imem_req_d;
   logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
   logic [INST_W-1:0] inst_q,       inst_d;
   logic              inst_valid_q, inst_valid_d;
   logic [ADDR_W-1:0] pc_out_q,     pc_out_d;
   logic              fetch_err_q,  fetch_err_d;
   logic              drop_q,       drop_d;
   logic [TCNT_W-1:0] tcnt_q,       tcnt_d;

   logic              can_load;
   logic              timeout_hit;
   logic              unused_pc_lsb;

   // Redirect targets are word aligned; the low bits carry no information.
   assign unused_pc_lsb = ^redirect_pc[1:0];

   // A new word may replace inst unless the held one is still stalled.
   assign can_load    = !inst_valid_q || !stall;
   assign timeout_hit = (tcnt_q == TCNT_LAST);

   // Next-state and next-output computation for the fetch FSM.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      imem_req_d   = imem_req_q;
      imem_addr_d  = imem_addr_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      pc_out_d     = pc_out_q;
      fetch_err_d  = fetch_err_q;
      drop_d       = drop_q;
      tcnt_d       = tcnt_q;

      // A valid instruction is consumed on any cycle without stall.
      if (inst_valid_q && !stall) begin
         inst_valid_d = 1'b0;
         inst_d       = NOP_INST;
      end

      unique case (state_q)
         ST_FETCH: begin
            // A redirect here just retargets the PC; no stale request is issued.
            if (!redirect_valid) begin
               imem_req_d  = 1'b1;
               imem_addr_d = pc_q;
               tcnt_d      = '0;
               state_d     = ST_WAIT;
            end
         end

         ST_WAIT: begin
            tcnt_d = tcnt_q + TCNT_W'(1);
            if (imem_ack) begin
               if (drop_q || redirect_valid) begin
                  // Returned word belongs to a squashed path.
                  imem_req_d = 1'b0;
                  drop_d     = 1'b0;
                  state_d    = ST_FETCH;
               end else if (can_load) begin
                  inst_d       = imem_rdata;
                  pc_out_d     = imem_addr_q;
                  inst_valid_d = 1'b1;
                  pc_d         = imem_addr_q + 32'd4;
                  imem_req_d   = 1'b0;
                  state_d      = stall ? ST_HOLD : ST_FETCH;
               end else begin
                  // Memory is responsive but the word cannot land yet; keep
                  // the request up and do not count this against the timeout.
                  tcnt_d = '0;
               end
            end else if (timeout_hit) begin
               fetch_err_d  = 1'b1;
               imem_req_d   = 1'b0;
               inst_valid_d = 1'b0;
               inst_d       = NOP_INST;
               drop_d       = 1'b0;
               state_d      = ST_ERR;
            end else if (redirect_valid) begin
               // Handshake must still complete; remember to discard its data.
               drop_d = 1'b1;
            end
         end

         ST_HOLD: begin
            if (!stall || redirect_valid) begin
               state_d = ST_FETCH;
            end
         end

         ST_ERR: begin
            imem_req_d   = 1'b0;
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
         end

         default: begin
            state_d = ST_ERR;
         end
      endcase

      // Redirect overrides stall and any accepted data, but never the fault.
      if (redirect_valid && (state_q != ST_ERR) && (state_d != ST_ERR)) begin
         pc_d         = word_align(redirect_pc);
         inst_valid_d = 1'b0;
         inst_d       = NOP_INST;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= RESET_PC;
         inst_q       <= NOP_INST;
         inst_valid_q <= 1'b0;
         pc_out_q     <= RESET_PC;
         fetch_err_q  <= 1'b0;
         drop_q       <= 1'b0;
         tcnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         imem_req_q   <= imem_req_d;
         imem_addr_q  <= imem_addr_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         pc_out_q     <= pc_out_d;
         fetch_err_q  <= fetch_err_d;
         drop_q       <= drop_d;
         tcnt_q       <= tcnt_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = imem_addr_q;
   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign pc_out     = pc_out_q;
   assign fetch_err  = fetch_err_q;

endmodule
